// File: rtl/ctrl_unit.sv
// Program sequencer and instruction decoder: owns the PC, a small call stack and the
// registered zero flag, and decodes each ROM word into ALU opcode and write strobes.
module ctrl_unit #(
    parameter int IWIDTH      = 4,
    parameter int DWIDTH      = 4,
    parameter int AWIDTH      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              CONT,
    input  logic [AWIDTH+4:0] INSTR,
    input  logic [DWIDTH-1:0] ALU_RESULT,
    output logic [AWIDTH-1:0] PC_OUT,
    output logic [IWIDTH-1:0] ALU_INSTR,
    output logic [AWIDTH-1:0] OPERAND,
    output logic              ACC_WE,
    output logic              MEM_WE,
    output logic              ACC_CLR,
    output logic              ZF,
    output logic              HALTED,
    output logic              ERR
);

    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int IDXW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IDXW;

    localparam logic [4:0] OP_LD   = 5'h0A;
    localparam logic [4:0] OP_ST   = 5'h0B;
    localparam logic [4:0] OP_SRST = 5'h0D;
    localparam logic [4:0] OP_JMP  = 5'h10;
    localparam logic [4:0] OP_JZ   = 5'h11;
    localparam logic [4:0] OP_JNZ  = 5'h12;
    localparam logic [4:0] OP_CALL = 5'h13;
    localparam logic [4:0] OP_RET  = 5'h14;
    localparam logic [4:0] OP_HLT  = 5'h15;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic              zf_q, zf_d;
    logic              err_q, err_d;
    logic [AWIDTH-1:0] stack_q [SLOTS];
    logic [AWIDTH-1:0] stack_d [SLOTS];

    logic [4:0]        op;
    logic [AWIDTH-1:0] operand;
    logic [AWIDTH-1:0] pc_inc;
    logic [SPW-1:0]    sp_dec;
    logic [IWIDTH-1:0] alu_instr;
    logic              acc_we, mem_we, acc_clr;

    assign op      = INSTR[AWIDTH+4:AWIDTH];
    assign operand = INSTR[AWIDTH-1:0];
    assign pc_inc  = pc_q + AWIDTH'(1);
    assign sp_dec  = sp_q - SPW'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        zf_d      = zf_q;
        err_d     = err_q;
        stack_d   = stack_q;
        acc_we    = 1'b0;
        mem_we    = 1'b0;
        acc_clr   = 1'b0;
        alu_instr = IWIDTH'(4'b1100);

        if (op < OP_LD) begin
            alu_instr = IWIDTH'(op[3:0]);
        end else if (op == OP_LD) begin
            alu_instr = IWIDTH'(4'b1010);
        end

        if (state_q == S_RUN) begin
            if (EN) begin
                case (op)
                    OP_ST: begin
                        mem_we = 1'b1;
                        pc_d   = pc_inc;
                    end
                    OP_SRST: begin
                        acc_clr = 1'b1;
                        pc_d    = '0;
                        sp_d    = '0;
                        zf_d    = 1'b0;
                    end
                    OP_JMP: pc_d = operand;
                    OP_JZ:  pc_d = zf_q ? operand : pc_inc;
                    OP_JNZ: pc_d = zf_q ? pc_inc : operand;
                    OP_CALL: begin
                        // A full stack halts with the PC left on the faulting CALL
                        if (sp_q == SPW'(STACK_DEPTH)) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            stack_d[sp_q[IDXW-1:0]] = pc_inc;
                            sp_d = sp_q + SPW'(1);
                            pc_d = operand;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            sp_d = sp_dec;
                            pc_d = stack_q[sp_dec[IDXW-1:0]];
                        end
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                        pc_d    = pc_inc;
                    end
                    default: begin
                        acc_we = (op <= OP_LD);
                        pc_d   = pc_inc;
                    end
                endcase
                if (acc_we) begin
                    zf_d = (ALU_RESULT == '0);
                end
            end
        end else if (CONT && !err_q) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            sp_q    <= '0;
            zf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            zf_q    <= zf_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; SP alone decides which entries are live
    always_ff @(posedge CLK) begin
        stack_q <= stack_d;
    end

    assign PC_OUT    = pc_q;
    assign ALU_INSTR = alu_instr;
    assign OPERAND   = operand;
    assign ACC_WE    = acc_we & RST;
    assign MEM_WE    = mem_we & RST;
    assign ACC_CLR   = acc_clr & RST;
    assign ZF        = zf_q;
    assign HALTED    = (state_q == S_HALT);
    assign ERR       = err_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: a behavioural ROM feeds INSTR from PC_OUT and each
// scenario checks PC flow, strobes and flags against hand-computed values.
module tb_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cont;
    logic [12:0] instr;
    logic [3:0]  alu_result;
    logic [7:0]  pc_out;
    logic [3:0]  alu_instr;
    logic [7:0]  operand;
    logic        acc_we, mem_we, acc_clr, zf, halted, err;

    logic [12:0] rom [256];
    int checks   = 0;
    int failures = 0;

    ctrl_unit #(.IWIDTH(4), .DWIDTH(4), .AWIDTH(8), .STACK_DEPTH(4)) dut (
        .CLK(clk), .RST(rst_n), .EN(en), .CONT(cont), .INSTR(instr),
        .ALU_RESULT(alu_result), .PC_OUT(pc_out), .ALU_INSTR(alu_instr),
        .OPERAND(operand), .ACC_WE(acc_we), .MEM_WE(mem_we), .ACC_CLR(acc_clr),
        .ZF(zf), .HALTED(halted), .ERR(err)
    );

    assign instr = rom[pc_out];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] enc(input logic [4:0] op, input logic [7:0] opd);
        return {op, opd};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic cont_v, input logic [3:0] res_v);
        en         = en_v;
        cont       = cont_v;
        alu_result = res_v;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = enc(5'h0C, 8'h00);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        cont       = 1'b0;
        alu_result = 4'd0;
        clearRom();

        // Asynchronous reset mid-run at PC 0x37 with ZF set
        rom[8'h00] = enc(5'h08, 8'h00);
        rom[8'h36] = enc(5'h08, 8'h00);
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd0);
        tick(8'h37);
        checkOutput("run_pc", 32'(pc_out), 32'h37);
        checkOutput("run_zf", 32'(zf), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pc", 32'(pc_out), 32'h00);
        checkOutput("rst_zf", 32'(zf), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_acc_we", 32'(acc_we), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_pc", 32'(pc_out), 32'h00);
        checkOutput("rst_hold_acc_we", 32'(acc_we), 32'h0);

        // DEC then JZ, taken and not taken
        clearRom();
        rom[8'h00] = enc(5'h08, 8'h00);
        rom[8'h01] = enc(5'h11, 8'h40);
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("dec_acc_we", 32'(acc_we), 32'h1);
        checkOutput("dec_alu_instr", 32'(alu_instr), 32'h8);
        tick(1);
        checkOutput("jz_zf", 32'(zf), 32'h1);
        checkOutput("jz_alu_default", 32'(alu_instr), 32'hC);
        checkOutput("jz_operand", 32'(operand), 32'h40);
        tick(1);
        checkOutput("jz_taken_pc", 32'(pc_out), 32'h40);
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd3);
        tick(1);
        checkOutput("jz_zf_clear", 32'(zf), 32'h0);
        tick(1);
        checkOutput("jz_not_taken_pc", 32'(pc_out), 32'h02);

        // CALL / RET
        clearRom();
        rom[8'h00] = enc(5'h10, 8'h10);
        rom[8'h10] = enc(5'h13, 8'h80);
        rom[8'h80] = enc(5'h14, 8'h00);
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd0);
        tick(1);
        checkOutput("call_pc", 32'(pc_out), 32'h10);
        tick(1);
        checkOutput("callee_pc", 32'(pc_out), 32'h80);
        tick(1);
        checkOutput("ret_pc", 32'(pc_out), 32'h11);
        checkOutput("ret_err", 32'(err), 32'h0);

        // Five nested CALLs overflow a 4-entry stack
        clearRom();
        rom[8'h00] = enc(5'h13, 8'h10);
        rom[8'h10] = enc(5'h13, 8'h20);
        rom[8'h20] = enc(5'h13, 8'h30);
        rom[8'h30] = enc(5'h13, 8'h40);
        rom[8'h40] = enc(5'h13, 8'h50);
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd0);
        tick(4);
        checkOutput("ovf_pre_pc", 32'(pc_out), 32'h40);
        checkOutput("ovf_pre_halted", 32'(halted), 32'h0);
        tick(1);
        checkOutput("ovf_pc", 32'(pc_out), 32'h40);
        checkOutput("ovf_err", 32'(err), 32'h1);
        checkOutput("ovf_halted", 32'(halted), 32'h1);
        applyStimulus(1'b1, 1'b1, 4'd0);
        tick(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        tick(1);
        checkOutput("ovf_cont_halted", 32'(halted), 32'h1);
        checkOutput("ovf_cont_pc", 32'(pc_out), 32'h40);

        // RET right after reset underflows
        clearRom();
        rom[8'h00] = enc(5'h14, 8'h00);
        resetDut();
        checkOutput("unf_reset_err", 32'(err), 32'h0);
        tick(1);
        checkOutput("unf_err", 32'(err), 32'h1);
        checkOutput("unf_halted", 32'(halted), 32'h1);
        checkOutput("unf_pc", 32'(pc_out), 32'h00);

        // HLT, resume with CONT, then stall a ST
        clearRom();
        rom[8'h00] = enc(5'h10, 8'h05);
        rom[8'h05] = enc(5'h15, 8'h00);
        rom[8'h06] = enc(5'h0B, 8'h00);
        resetDut();
        tick(1);
        checkOutput("hlt_pc", 32'(pc_out), 32'h05);
        checkOutput("hlt_pre_halted", 32'(halted), 32'h0);
        tick(1);
        checkOutput("halted", 32'(halted), 32'h1);
        checkOutput("halted_pc", 32'(pc_out), 32'h06);
        checkOutput("halted_mem_we", 32'(mem_we), 32'h0);
        tick(1);
        checkOutput("halted_hold_pc", 32'(pc_out), 32'h06);
        applyStimulus(1'b1, 1'b1, 4'd0);
        tick(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("resume_halted", 32'(halted), 32'h0);
        checkOutput("resume_pc", 32'(pc_out), 32'h06);
        checkOutput("resume_mem_we", 32'(mem_we), 32'h1);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("stall_mem_we", 32'(mem_we), 32'h0);
        tick(1);
        checkOutput("stall_pc", 32'(pc_out), 32'h06);
        applyStimulus(1'b1, 1'b0, 4'd0);
        tick(1);
        checkOutput("unstall_pc", 32'(pc_out), 32'h07);

        // PC wrap at 0xFF
        clearRom();
        rom[8'h00] = enc(5'h10, 8'hFF);
        resetDut();
        tick(1);
        checkOutput("wrap_pre_pc", 32'(pc_out), 32'hFF);
        tick(1);
        checkOutput("wrap_pc", 32'(pc_out), 32'h00);

        // Soft-reset opcode clears ZF and returns to 0
        clearRom();
        rom[8'h00] = enc(5'h08, 8'h00);
        rom[8'h01] = enc(5'h10, 8'h20);
        rom[8'h20] = enc(5'h0D, 8'h00);
        resetDut();
        tick(2);
        checkOutput("srst_pc", 32'(pc_out), 32'h20);
        checkOutput("srst_pre_zf", 32'(zf), 32'h1);
        checkOutput("srst_acc_clr", 32'(acc_clr), 32'h1);
        checkOutput("srst_acc_we", 32'(acc_we), 32'h0);
        tick(1);
        checkOutput("srst_next_pc", 32'(pc_out), 32'h00);
        checkOutput("srst_zf", 32'(zf), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
